mips_avalon_arbiter: RTL and testbench
======================================

# mips_avalon_arbiter

Two-master, one-slave Avalon memory-mapped arbiter placed between the MIPS CPU's instruction-fetch port and data port and the single shared Avalon memory slave. It serialises transactions with a registered round-robin grant, forwards the granted master's signals to the slave, and stalls the other master with waitrequest. It also keeps per-master completed-transaction counters, a watchdog timeout and sticky protocol-error flags for the testbench.

## Interface

- TIMEOUT, 64: maximum consecutive cycles a granted transaction may see avm_waitrequest high before being aborted.
- COUNT_WIDTH, 32: width of the transaction counters.

- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_address  in  32  fetch byte address.
- instr_read  in  1  fetch read request.
- instr_waitrequest  out  1  stall to fetch master.
- instr_readdata  out  32  fetch read data.
- data_address  in  32  data byte address.
- data_read  in  1  data read request.
- data_write  in  1  data write request.
- data_writedata  in  32  store data.
- data_byteenable  in  4  store/load byte lanes.
- data_waitrequest  out  1  stall to data master.
- data_readdata  out  32  load data.
- avm_address  out  32  to slave.
- avm_read  out  1  to slave.
- avm_write  out  1  to slave.
- avm_writedata  out  32  to slave.
- avm_byteenable  out  4  to slave.
- avm_waitrequest  in  1  from slave.
- avm_readdata  in  32  from slave.
- instr_count  out  COUNT_WIDTH  completed fetch transactions.
- data_count  out  COUNT_WIDTH  completed data transactions.
- timeout_err  out  1  sticky watchdog flag.
- protocol_err  out  1  sticky protocol-violation flag.

## Operation

- States: IDLE, GRANT_I, GRANT_D. Reset -> IDLE.
- Request definitions: req_i = instr_read; req_d = data_read | data_write.
- IDLE: avm_read/avm_write/avm_address/avm_writedata/avm_byteenable all 0. Next edge: only req_i -> GRANT_I; only req_d -> GRANT_D; both -> the master NOT recorded in last_grant (reset value of last_grant = instruction, so data wins first contention).
- GRANT_I: avm_address = instr_address, avm_read = instr_read, avm_write = 0, avm_byteenable = 4'b1111, avm_writedata = 0. instr_waitrequest = avm_waitrequest.
- GRANT_D: all avm_* driven combinationally from data_* . data_waitrequest = avm_waitrequest.
- Non-granted master (and both in IDLE): waitrequest = 1.
- instr_readdata and data_readdata both = avm_readdata at all times; valid only on the owner's completion cycle.
- Completion: granted request high and avm_waitrequest low. On that edge: owner counter += 1 (wraps modulo 2^COUNT_WIDTH), last_grant <= owner; next state = grant of the other master if its request is high, else IDLE. Same master never regranted directly; back-to-back same-master transactions pass through IDLE.
- Watchdog: wait_ctr cleared on entering any grant state, increments each granted cycle with avm_waitrequest high. If wait_ctr == TIMEOUT-1 and avm_waitrequest still high: next edge -> IDLE, timeout_err <= 1, no count increment, last_grant <= owner.
- Protocol errors (set protocol_err, sticky): data_read & data_write both high in any cycle; granted master drops its request before completion (arbiter returns to IDLE on that edge, no count increment).
- timeout_err, protocol_err cleared only by reset.

## Timing

- Reset (async): state IDLE, last_grant = instruction, counters 0, flags 0, wait_ctr 0; outputs: avm_* 0, both waitrequests 1.
- Arbitration latency: request asserted in cycle N (from IDLE) reaches slave in cycle N+1.
- Transaction length = 1 grant cycle + slave wait cycles; completion cycle has waitrequest low.
- Handover under contention: zero idle cycles; other master's request appears on avm_* the cycle after completion.
- Master must hold address/data/byteenable/request stable while its waitrequest is high.
- Reset mid-transaction: slave request drops immediately (asynchronous), no counter update.

## Test plan

- Fetch only: instr_read=1, instr_address=0xBFC00000, slave delay 2 -> avm_read high from cycle 1, instr_waitrequest low on completion with slave data, instr_count=1, data_waitrequest=1 throughout.
- Simultaneous first request: instr_read and data_write (addr 0x10, data 0xDEADBEEF, be 4'b0011) in cycle 0 -> data granted first, write reaches slave with be 0011, then fetch granted next cycle with no gap; data_count=1, instr_count=1.
- Sustained contention: both masters request continuously for 8 transactions -> grants strictly alternate D,I,D,I...; counts 4 and 4.
- Back-to-back same master: data reads to 0x0, 0x4 -> one IDLE cycle between them, avm_read low for that cycle.
- Watchdog: slave holds avm_waitrequest high, TIMEOUT=8 -> after 8 grant cycles state IDLE, timeout_err=1, counters unchanged.
- Protocol/reset: data_read and data_write both high -> protocol_err=1; assert reset mid-transaction -> avm_read/avm_write 0 same cycle, flags and counters 0.

Source files
------------

// File: rtl/mips_avalon_arbiter.sv
// ---------------------------------------------------------------------------
// mips_avalon_arbiter
//
// Shares one Avalon-MM slave between the MIPS instruction-fetch master and
// the data master. Grants are registered and alternate under contention
// (round-robin), so one master can never starve the other. The granted
// master's signals are forwarded combinationally to the slave, and the
// other master is held off with waitrequest.
//
// Debug/observation outputs: per-master completed-transaction counters, a
// sticky watchdog flag and a sticky protocol-violation flag.
//
// Ports
//   clk, reset            clock (rising edge) and async active-high reset
//   instr_*               fetch master: address/read in, waitrequest/readdata out
//   data_*                data master: address/read/write/writedata/byteenable in,
//                         waitrequest/readdata out
//   avm_*                 shared slave: address/read/write/writedata/byteenable
//                         out, waitrequest/readdata in
//   instr_count/data_count  completed transactions per master (wrapping)
//   timeout_err           set when a grant sees TIMEOUT stalled cycles
//   protocol_err          set on read+write together or a request dropped
//                         before completion
// ---------------------------------------------------------------------------
module mips_avalon_arbiter #(
   parameter int TIMEOUT     = 64,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            instr_address,
   input  logic                   instr_read,
   output logic                   instr_waitrequest,
   output logic [31:0]            instr_readdata,
   input  logic [31:0]            data_address,
   input  logic                   data_read,
   input  logic                   data_write,
   input  logic [31:0]            data_writedata,
   input  logic [3:0]             data_byteenable,
   output logic                   data_waitrequest,
   output logic [31:0]            data_readdata,
   output logic [31:0]            avm_address,
   output logic                   avm_read,
   output logic                   avm_write,
   output logic [31:0]            avm_writedata,
   output logic [3:0]             avm_byteenable,
   input  logic                   avm_waitrequest,
   input  logic [31:0]            avm_readdata,
   output logic [COUNT_WIDTH-1:0] instr_count,
   output logic [COUNT_WIDTH-1:0] data_count,
   output logic                   timeout_err,
   output logic                   protocol_err
);

   // The wait counter only has to reach TIMEOUT-1, so it is sized for that.
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   state_t            state;
   logic              last_grant;
   logic [WAIT_W-1:0] wait_ctr;

   logic req_i;
   logic req_d;
   logic wait_last;

   assign req_i     = instr_read;
   assign req_d     = data_read | data_write;
   assign wait_last = (wait_ctr == WAIT_W'(TIMEOUT - 1));

   // Read data is broadcast to both masters; each only looks at it on its
   // own completion cycle.
   assign instr_readdata = avm_readdata;
   assign data_readdata  = avm_readdata;

   // Slave-side mux: forward the owner's request, stall everyone else.
   always_comb begin
      avm_address       = 32'h0;
      avm_read          = 1'b0;
      avm_write         = 1'b0;
      avm_writedata     = 32'h0;
      avm_byteenable    = 4'h0;
      instr_waitrequest = 1'b1;
      data_waitrequest  = 1'b1;
      case (state)
         GRANT_I: begin
            avm_address       = instr_address;
            avm_read          = instr_read;
            avm_byteenable    = 4'b1111;
            instr_waitrequest = avm_waitrequest;
         end
         GRANT_D: begin
            avm_address      = data_address;
            avm_read         = data_read;
            avm_write        = data_write;
            avm_writedata    = data_writedata;
            avm_byteenable   = data_byteenable;
            data_waitrequest = avm_waitrequest;
         end
         default: ;
      endcase
   end

   // Arbitration FSM with counters and sticky flags. A finished owner hands
   // straight over to the other master if it is waiting, otherwise the
   // arbiter goes idle, so the same master is never regranted without an
   // IDLE cycle in between. Stalls and dropped requests also fall back to
   // IDLE without counting a completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         last_grant   <= OWNER_I;
         wait_ctr     <= '0;
         instr_count  <= '0;
         data_count   <= '0;
         timeout_err  <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         if (data_read && data_write) begin
            protocol_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               wait_ctr <= '0;
               if (req_i && req_d) begin
                  state <= (last_grant == OWNER_I) ? GRANT_D : GRANT_I;
               end else if (req_i) begin
                  state <= GRANT_I;
               end else if (req_d) begin
                  state <= GRANT_D;
               end
            end
            GRANT_I: begin
               if (!req_i) begin
                  protocol_err <= 1'b1;
                  wait_ctr     <= '0;
                  state        <= IDLE;
               end else if (!avm_waitrequest) begin
                  instr_count <= instr_count + COUNT_WIDTH'(1);
                  last_grant  <= OWNER_I;
                  wait_ctr    <= '0;
                  state       <= req_d ? GRANT_D : IDLE;
               end else if (wait_last) begin
                  timeout_err <= 1'b1;
                  last_grant  <= OWNER_I;
                  wait_ctr    <= '0;
                  state       <= IDLE;
               end else begin
                  wait_ctr <= wait_ctr + WAIT_W'(1);
               end
            end
            GRANT_D: begin
               if (!req_d) begin
                  protocol_err <= 1'b1;
                  wait_ctr     <= '0;
                  state        <= IDLE;
               end else if (!avm_waitrequest) begin
                  data_count <= data_count + COUNT_WIDTH'(1);
                  last_grant <= OWNER_D;
                  wait_ctr   <= '0;
                  state      <= req_i ? GRANT_I : IDLE;
               end else if (wait_last) begin
                  timeout_err <= 1'b1;
                  last_grant  <= OWNER_D;
                  wait_ctr    <= '0;
                  state       <= IDLE;
               end else begin
                  wait_ctr <= wait_ctr + WAIT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_avalon_arbiter
//
// Directed scenarios followed by a randomized phase. The bench plays both
// masters and the slave, and keeps a transaction-level reference model
// (who owns the bus, who was served last, how long the owner has stalled)
// that predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_mips_avalon_arbiter;

   localparam int TIMEOUT = 8;
   localparam int M_NONE  = 0;
   localparam int OWN_I   = 1;
   localparam int OWN_D   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_address;
   logic        instr_read;
   logic        instr_waitrequest;
   logic [31:0] instr_readdata;
   logic [31:0] data_address;
   logic        data_read;
   logic        data_write;
   logic [31:0] data_writedata;
   logic [3:0]  data_byteenable;
   logic        data_waitrequest;
   logic [31:0] data_readdata;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic [31:0] instr_count;
   logic [31:0] data_count;
   logic        timeout_err;
   logic        protocol_err;

   int evaluated = 0;
   int failures  = 0;

   // Reference model state
   int          mOwner;
   int          mLast;
   int          mStall;
   logic [31:0] mCntI;
   logic [31:0] mCntD;
   logic        mTimeoutErr;
   logic        mProtErr;
   bit          mDoneI;
   bit          mDoneD;
   bit          mTimedOut;
   int          order[$];

   // Slave behaviour: 0 = fixed delay, 1 = stuck busy, 2 = random
   int   slaveMode;
   int   slaveDelay;
   logic sampledAvmRead;
   int   cycles;

   always #5 clk = ~clk;

   mips_avalon_arbiter #(.TIMEOUT(TIMEOUT), .COUNT_WIDTH(32)) dut (
      .clk(clk),
      .reset(reset),
      .instr_address(instr_address),
      .instr_read(instr_read),
      .instr_waitrequest(instr_waitrequest),
      .instr_readdata(instr_readdata),
      .data_address(data_address),
      .data_read(data_read),
      .data_write(data_write),
      .data_writedata(data_writedata),
      .data_byteenable(data_byteenable),
      .data_waitrequest(data_waitrequest),
      .data_readdata(data_readdata),
      .avm_address(avm_address),
      .avm_read(avm_read),
      .avm_write(avm_write),
      .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata),
      .instr_count(instr_count),
      .data_count(data_count),
      .timeout_err(timeout_err),
      .protocol_err(protocol_err)
   );

   // Hard stop in case something never completes.
   initial begin
      #300000;
      $display("[TB] FAIL global_timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      evaluated++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic iRead, input logic [31:0] iAddr,
                                input logic dRead, input logic dWrite,
                                input logic [31:0] dAddr, input logic [31:0] dWdata,
                                input logic [3:0] dBe);
      instr_read      = iRead;
      instr_address   = iAddr;
      data_read       = dRead;
      data_write      = dWrite;
      data_address    = dAddr;
      data_writedata  = dWdata;
      data_byteenable = dBe;
   endtask

   task automatic modelReset();
      mOwner      = M_NONE;
      mLast       = OWN_I;
      mStall      = 0;
      mCntI       = 32'h0;
      mCntD       = 32'h0;
      mTimeoutErr = 1'b0;
      mProtErr    = 1'b0;
      mDoneI      = 1'b0;
      mDoneD      = 1'b0;
      mTimedOut   = 1'b0;
   endtask

   // Advance the model by one clock using this cycle's inputs.
   task automatic modelEdge();
      bit reqI;
      bit reqD;
      bit ownReq;
      bit otherReq;
      reqI      = instr_read;
      reqD      = data_read | data_write;
      mDoneI    = 1'b0;
      mDoneD    = 1'b0;
      mTimedOut = 1'b0;
      if (data_read && data_write) mProtErr = 1'b1;
      if (mOwner == M_NONE) begin
         // Under contention the master not served last wins: 3 - last.
         if (reqI && reqD)  mOwner = 3 - mLast;
         else if (reqI)     mOwner = OWN_I;
         else if (reqD)     mOwner = OWN_D;
         mStall = 0;
      end else begin
         ownReq   = (mOwner == OWN_I) ? reqI : reqD;
         otherReq = (mOwner == OWN_I) ? reqD : reqI;
         if (!ownReq) begin
            mProtErr = 1'b1;
            mOwner   = M_NONE;
            mStall   = 0;
         end else if (!avm_waitrequest) begin
            if (mOwner == OWN_I) begin mCntI++; mDoneI = 1'b1; end
            else                 begin mCntD++; mDoneD = 1'b1; end
            order.push_back(mOwner);
            mLast  = mOwner;
            mOwner = otherReq ? (3 - mOwner) : M_NONE;
            mStall = 0;
         end else begin
            mStall++;
            if (mStall >= TIMEOUT) begin
               mTimeoutErr = 1'b1;
               mTimedOut   = 1'b1;
               mLast       = mOwner;
               mOwner      = M_NONE;
               mStall      = 0;
            end
         end
      end
   endtask

   task automatic checkAll();
      logic [69:0] expAvm;
      logic [1:0]  expWr;
      case (mOwner)
         OWN_I: begin
            expAvm = {instr_address, instr_read, 1'b0, 32'h0, 4'hF};
            expWr  = {avm_waitrequest, 1'b1};
         end
         OWN_D: begin
            expAvm = {data_address, data_read, data_write, data_writedata, data_byteenable};
            expWr  = {1'b1, avm_waitrequest};
         end
         default: begin
            expAvm = '0;
            expWr  = 2'b11;
         end
      endcase
      checkOutput("avm_bus", {avm_address, avm_read, avm_write, avm_writedata, avm_byteenable}, expAvm);
      checkOutput("waitrequest", {instr_waitrequest, data_waitrequest}, expWr);
      checkOutput("readdata", {instr_readdata, data_readdata}, {avm_readdata, avm_readdata});
      checkOutput("counts", {instr_count, data_count}, {mCntI, mCntD});
      checkOutput("flags", {timeout_err, protocol_err}, {mTimeoutErr, mProtErr});
   endtask

   // One clock: slave responds, outputs checked at negedge, model advances,
   // and any master whose transaction just completed goes idle.
   task automatic runCycle();
      case (slaveMode)
         0:       avm_waitrequest = (mOwner != M_NONE) && (mStall < slaveDelay);
         1:       avm_waitrequest = 1'b1;
         default: avm_waitrequest = 1'($urandom_range(0, 1));
      endcase
      avm_readdata = $urandom;
      @(negedge clk);
      checkAll();
      sampledAvmRead = avm_read;
      modelEdge();
      @(posedge clk);
      #1;
      if (mDoneI) instr_read = 1'b0;
      if (mDoneD) begin
         data_read  = 1'b0;
         data_write = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      avm_waitrequest = 1'b0;
      avm_readdata    = 32'h0;
      slaveMode       = 0;
      slaveDelay      = 0;
      modelReset();

      // Reset state
      #3;
      checkAll();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Fetch only, slave delay 2
      slaveDelay = 2;
      applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      cycles = 0;
      do begin runCycle(); cycles++; end while (!mDoneI && cycles < 20);
      checkOutput("fetch_cycles", cycles, 4);
      checkOutput("fetch_count", instr_count, 1);
      runCycle();

      // Simultaneous first request: data wins, fetch follows with no gap
      slaveDelay = 1;
      order.delete();
      applyStimulus(1'b1, 32'h00400000, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b0011);
      cycles = 0;
      do begin runCycle(); cycles++; end while (order.size() < 2 && cycles < 30);
      checkOutput("contention_cycles", cycles, 5);
      checkOutput("first_grant", (order.size() > 0) ? order[0] : M_NONE, OWN_D);
      checkOutput("second_grant", (order.size() > 1) ? order[1] : M_NONE, OWN_I);
      checkOutput("contention_counts", {instr_count, data_count}, {32'd2, 32'd1});

      // Sustained contention for 8 transactions: strict alternation
      order.delete();
      cycles = 0;
      while (order.size() < 8 && cycles < 100) begin
         if (!instr_read) begin
            instr_read    = 1'b1;
            instr_address = $urandom & 32'hFFFF_FFFC;
         end
         if (!data_read && !data_write) begin
            data_read       = 1'b1;
            data_address    = $urandom & 32'hFFFF_FFFC;
            data_byteenable = 4'hF;
         end
         runCycle();
         cycles++;
      end
      for (int n = 0; n < 8; n++) begin
         checkOutput("alternation", (order.size() > n) ? order[n] : M_NONE,
                     (n % 2 == 0) ? OWN_D : OWN_I);
      end
      checkOutput("sustained_counts", {instr_count, data_count}, {32'd6, 32'd5});
      cycles = 0;
      while ((instr_read || data_read || data_write) && cycles < 30) begin
         runCycle();
         cycles++;
      end

      // Back-to-back data reads pass through one IDLE cycle
      slaveDelay = 0;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
      cycles = 0;
      do begin runCycle(); cycles++; end while (!mDoneD && cycles < 20);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
      runCycle();
      checkOutput("b2b_gap_read", sampledAvmRead, 1'b0);
      cycles = 1;
      while (!mDoneD && cycles < 20) begin runCycle(); cycles++; end
      checkOutput("b2b_second_cycles", cycles, 2);
      checkOutput("b2b_count", data_count, 8);

      // Watchdog: slave never ready
      slaveMode = 1;
      applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      cycles = 0;
      do begin runCycle(); cycles++; end while (!mTimedOut && cycles < 30);
      checkOutput("watchdog_cycles", cycles, TIMEOUT + 1);
      checkOutput("watchdog_flag", timeout_err, 1'b1);
      checkOutput("watchdog_counts", {instr_count, data_count}, {32'd6, 32'd8});
      slaveMode = 0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      runCycle();

      // Protocol errors: read+write together, then owner drops its request
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h5, 4'hF);
      runCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      runCycle();
      checkOutput("protocol_flag", protocol_err, 1'b1);

      // Reset in the middle of a granted fetch
      slaveDelay = 3;
      applyStimulus(1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      runCycle();
      runCycle();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst_avm_rw", {avm_read, avm_write}, 2'b00);
      checkOutput("rst_flags_counts", {timeout_err, protocol_err, instr_count, data_count}, 66'h0);
      modelReset();
      checkAll();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Randomized traffic against the model
      slaveMode = 2;
      for (int k = 0; k < 800; k++) begin
         if (!instr_read) begin
            if ($urandom_range(0, 3) == 0) begin
               instr_read    = 1'b1;
               instr_address = $urandom & 32'hFFFF_FFFC;
            end else begin
               instr_address = $urandom;
            end
         end
         if (!data_read && !data_write) begin
            data_address    = $urandom & 32'hFFFF_FFFC;
            data_writedata  = $urandom;
            data_byteenable = 4'($urandom);
            if ($urandom_range(0, 2) == 0) begin
               if ($urandom_range(0, 1) == 1) data_read  = 1'b1;
               else                           data_write = 1'b1;
            end
         end
         runCycle();
      end
      slaveMode  = 0;
      slaveDelay = 0;
      cycles = 0;
      while ((instr_read || data_read || data_write) && cycles < 50) begin
         runCycle();
         cycles++;
      end
      checkOutput("drain_done", {instr_read, data_read, data_write}, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
      $finish;
   end

endmodule
